// File: rtl/hqm_rcfwl_gclk_refclk_synchk.sv
// Receive-side checker for the distributed divide-by-4 reference clock.
// Acquires phase after each sync edge, tracks it, and reports lock health.
module hqm_rcfwl_gclk_refclk_synchk #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_ERR = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 x4clk_in,
  input  logic                 rst,
  input  logic                 sync_in,
  input  logic                 ref_clk_samp_in,
  input  logic                 err_clr,
  output logic                 sync_edge_out,
  output logic                 locked,
  output logic                 lock_lost,
  output logic [1:0]           phase,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } st_t;

  localparam logic [3:0] LC = 4'(LOCK_CNT);
  localparam logic [3:0] UE = 4'(UNLOCK_ERR);

  st_t        st, st_n;
  logic       sync_q, samp_q;
  logic [1:0] ph, ph_n;
  logic [3:0] good, good_n;
  logic [3:0] miss, miss_n;
  logic [2:0] tmr, tmr_n;
  logic       bad, bad_n;
  logic       err_inc, lost_n;
  logic       sync_rise, trans, mism;

  assign sync_rise = sync_in & ~sync_q;
  assign trans     = ref_clk_samp_in ^ samp_q;
  // transitions belong on the even phases only
  assign mism      = trans != ~ph[0];
  assign phase     = ph;

  always_comb begin
    st_n    = st;
    ph_n    = ph;
    good_n  = good;
    miss_n  = miss;
    tmr_n   = tmr;
    bad_n   = bad;
    err_inc = 1'b0;
    lost_n  = 1'b0;
    if (sync_rise) begin
      st_n   = ACQ;
      ph_n   = 2'd0;
      good_n = 4'd0;
      miss_n = 4'd0;
      tmr_n  = 3'd0;
      bad_n  = 1'b0;
      lost_n = (st == LOCKED);
    end else begin
      unique case (st)
        IDLE: ;
        ACQ: begin
          if (trans) begin
            st_n   = TRACK;
            ph_n   = 2'd1;
            good_n = 4'd0;
          end else if (tmr == 3'd7) begin
            err_inc = 1'b1;
            tmr_n   = 3'd0;
          end else begin
            tmr_n = tmr + 3'd1;
          end
        end
        TRACK: begin
          ph_n = ph + 2'd1;
          if (mism) begin
            st_n    = ACQ;
            ph_n    = 2'd0;
            good_n  = 4'd0;
            tmr_n   = 3'd0;
            err_inc = 1'b1;
          end else if (ph == 2'd3) begin
            good_n = good + 4'd1;
            if (good + 4'd1 == LC) begin
              st_n   = LOCKED;
              miss_n = 4'd0;
              bad_n  = 1'b0;
            end
          end
        end
        LOCKED: begin
          ph_n = ph + 2'd1;
          if (mism) begin
            err_inc = 1'b1;
            miss_n  = miss + 4'd1;
            bad_n   = (ph != 2'd3);
            if (miss + 4'd1 == UE) begin
              st_n   = ACQ;
              lost_n = 1'b1;
              ph_n   = 2'd0;
              good_n = 4'd0;
              miss_n = 4'd0;
              tmr_n  = 3'd0;
              bad_n  = 1'b0;
            end
          end else if (ph == 2'd3) begin
            bad_n = 1'b0;
            if (!bad) miss_n = 4'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge x4clk_in) begin
    if (rst) begin
      st            <= IDLE;
      sync_q        <= 1'b0;
      samp_q        <= 1'b0;
      ph            <= 2'd0;
      good          <= 4'd0;
      miss          <= 4'd0;
      tmr           <= 3'd0;
      bad           <= 1'b0;
      sync_edge_out <= 1'b0;
      locked        <= 1'b0;
      lock_lost     <= 1'b0;
      err_cnt       <= '0;
    end else begin
      st            <= st_n;
      sync_q        <= sync_in;
      samp_q        <= ref_clk_samp_in;
      ph            <= ph_n;
      good          <= good_n;
      miss          <= miss_n;
      tmr           <= tmr_n;
      bad           <= bad_n;
      sync_edge_out <= sync_rise;
      locked        <= (st_n == LOCKED);
      lock_lost     <= lost_n;
      if (err_clr)
        err_cnt <= '0;
      else if (err_inc && !(&err_cnt))
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
